imem_responder: RTL and testbench

- Instruction-memory responder: the far end of the fetch interface driven by the program counter.
- Accepts fetch addresses over a valid/ready request channel and reads a word-addressed internal instruction store after a fixed pipeline latency.
- Returns instruction words in request order over a valid/ready response channel, buffered in a small response FIFO.
- Sits between the PC/fetch stage and decode. A side-band load port preloads the store from the bench or boot logic.

---
 rtl/imem_responder.sv | 113 +++++++++++
 tb/tb_imem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction store behind a credit-limited request channel and a response FIFO (optional flush port: IMEM_FLUSH_EN)
module imem_responder #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] START_ADDR = 32'h80000000,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [WIDTH-1:0]      req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_inst,
  output logic [WIDTH-1:0]      resp_addr,
  output logic                  resp_err,
  input  logic                  resp_ready,
  input  logic                  ld_wen,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data
`ifdef IMEM_FLUSH_EN
  ,
  input  logic                  flush
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic fl, live, acc, push, pop;
  logic [WIDTH-1:0] off;
  logic in_err;
  logic [DEPTH_LOG2-1:0] in_idx;
  int occ;
  logic [LATENCY:1] v;
  logic [LATENCY:1] se;
  logic [WIDTH-1:0] sa [1:LATENCY];
  logic [DEPTH_LOG2-1:0] si [1:LATENCY];
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] fi [FIFO_DEPTH];
  logic [WIDTH-1:0] fa [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fe;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
`ifdef IMEM_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  // decode the fetch address and count outstanding credits (pipeline + FIFO)
  always_comb begin
    off = req_addr - START_ADDR;
    // base is word-aligned, so off[1:0] equals req_addr[1:0]
    in_err = |off[1:0] || |off[WIDTH-1:DEPTH_LOG2+2];
    in_idx = off[DEPTH_LOG2+1:2];
    occ = int'(cnt);
    for (int k = 1; k <= LATENCY; k++) occ += int'(v[k]);
  end
  assign req_ready  = live && !fl && occ < FIFO_DEPTH;
  assign acc        = req_valid && req_ready;
  assign push       = v[LATENCY] && !fl;
  assign resp_valid = cnt != '0;
  assign pop        = resp_valid && resp_ready && !fl;
  assign resp_inst  = resp_valid ? fi[rp] : '0;
  assign resp_addr  = resp_valid ? fa[rp] : '0;
  assign resp_err   = resp_valid && fe[rp];
  // pipeline valid bits and the out-of-reset flag that gates req_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= 1'b0;
      v <= '0;
    end else begin
      live <= 1'b1;
      v[1] <= acc;
      for (int k = 2; k <= LATENCY; k++) v[k] <= v[k-1] && !fl;
    end
  end
  // pipeline payload travels unconditionally; only the valid bits matter
  always_ff @(posedge clk) begin
    sa[1] <= req_addr;
    se[1] <= in_err;
    si[1] <= in_idx;
    for (int k = 2; k <= LATENCY; k++) begin
      sa[k] <= sa[k-1];
      se[k] <= se[k-1];
      si[k] <= si[k-1];
    end
  end
  // FIFO pointers and occupancy; flush outranks push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (fl) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // store load port and final-stage read; nonblocking write gives read-before-write
  always_ff @(posedge clk) begin
    if (ld_wen) mem[ld_addr] <= ld_data;
    if (push) begin
      fi[wp] <= se[LATENCY] ? '0 : mem[si[LATENCY]];
      fa[wp] <= sa[LATENCY];
      fe[wp] <= se[LATENCY];
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of imem_responder against a queue-based reference model
module tb_imem_responder;
  localparam int L = 2;
  localparam int D = 4;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, resp_valid, resp_err, resp_ready = 0, ld_wen = 0, flush = 0;
  logic [31:0] req_addr = 0, resp_inst, resp_addr, ld_data = 0;
  logic [9:0] ld_addr = 0;
  typedef struct {logic [31:0] a; int due;} pend_t;
  typedef struct {logic [31:0] inst; logic [31:0] a; logic err;} rsp_t;
  pend_t pq[$];
  rsp_t fq[$];
  logic [31:0] mm [1024];
  bit live = 0, chk_on = 0;
  int n = 0, nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  imem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_err(resp_err),
    .resp_ready(resp_ready), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_FLUSH_EN
    , .flush(flush)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t expect_of(input logic [31:0] a);
    rsp_t r;
    logic [31:0] off;
    off = a - 32'h80000000;
    r.a = a;
    r.err = (a[1:0] != 2'b00) || (off >= 32'd4096);
    r.inst = r.err ? 32'h0 : mm[off[11:2]];
    return r;
  endfunction

  function automatic bit m_ready();
    return live && !flush && (pq.size() + fq.size() < D);
  endfunction

  task automatic model_step();
    bit acc;
    n++;
    if (!rst) begin
      pq.delete();
      fq.delete();
      live = 0;
      if (ld_wen) mm[ld_addr] = ld_data;
      return;
    end
    acc = req_valid && m_ready();
    if (flush) begin
      pq.delete();
      fq.delete();
    end else begin
      if (fq.size() != 0 && resp_ready) void'(fq.pop_front());
      while (pq.size() != 0 && pq[0].due == n) begin
        fq.push_back(expect_of(pq[0].a));
        void'(pq.pop_front());
      end
    end
    if (ld_wen) mm[ld_addr] = ld_data;
    if (acc) pq.push_back('{a: req_addr, due: n + L});
    live = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 0;
    resp_ready = 1;
    repeat (8) cyc();
  endtask

  task automatic fetch_one(input logic [31:0] a, output rsp_t r);
    int k;
    resp_ready = 1;
    req_valid = 1;
    req_addr = a;
    k = 0;
    while (!req_ready && k < 20) begin cyc(); k++; end
    cyc();
    req_valid = 0;
    k = 0;
    while (!resp_valid && k < 20) begin cyc(); k++; end
    chk("fetch_resp_valid", {31'b0, resp_valid}, 32'd1);
    r.inst = resp_inst;
    r.a = resp_addr;
    r.err = resp_err;
  endtask

  function automatic logic [31:0] rand_addr();
    int c;
    c = $urandom_range(0, 9);
    if (c < 7) return 32'h80000000 + ($urandom_range(0, 1023) << 2);
    if (c == 7) return 32'h80000000 + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
    if (c == 8) return 32'h80001000 + ($urandom_range(0, 255) << 2);
    return 32'h80000000 - ($urandom_range(1, 64) << 2);
  endfunction

  // every cycle: outputs against the model's current queues
  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready()});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, fq.size() != 0});
      if (fq.size() != 0) begin
        chk("resp_inst", resp_inst, fq[0].inst);
        chk("resp_addr", resp_addr, fq[0].a);
        chk("resp_err", {31'b0, resp_err}, {31'b0, fq[0].err});
      end else begin
        chk("idle_inst", resp_inst, 32'h0);
        chk("idle_addr", resp_addr, 32'h0);
        chk("idle_err", {31'b0, resp_err}, 32'h0);
      end
    end
  end

  initial begin
    rsp_t r;
    int acc, k;
    #1 rst = 0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_inst", resp_inst, 32'h0);
    chk("rst_resp_addr", resp_addr, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk_on = 1;
    cyc();
    cyc();
    rst = 1;
    cyc();
    chk("ready_after_release", {31'b0, req_ready}, 32'd1);
    // preload the whole store so every read is defined
    for (int i = 0; i < 1024; i++) begin
      ld_wen = 1;
      ld_addr = 10'(i);
      ld_data = (i == 0) ? 32'h00000413 : (i == 1) ? 32'h00100493 : (i == 5) ? 32'h0BADF00D : $urandom;
      cyc();
    end
    ld_wen = 0;
    drain();
    // latency: two back-to-back fetches
    req_valid = 1;
    req_addr = 32'h80000000;
    cyc();
    chk("lat_a1_valid", {31'b0, resp_valid}, 32'd0);
    req_addr = 32'h80000004;
    cyc();
    chk("lat_a2_valid", {31'b0, resp_valid}, 32'd0);
    req_valid = 0;
    cyc();
    chk("lat_w0_valid", {31'b0, resp_valid}, 32'd1);
    chk("lat_w0_inst", resp_inst, 32'h00000413);
    chk("lat_w0_addr", resp_addr, 32'h80000000);
    chk("lat_w0_err", {31'b0, resp_err}, 32'd0);
    cyc();
    chk("lat_w1_valid", {31'b0, resp_valid}, 32'd1);
    chk("lat_w1_inst", resp_inst, 32'h00100493);
    chk("lat_w1_addr", resp_addr, 32'h80000004);
    drain();
    // backpressure: credits stop the producer at FIFO_DEPTH
    resp_ready = 0;
    req_valid = 1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'h80000008 + 32'(4 * i);
      if (req_ready) acc++;
      cyc();
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
    req_valid = 0;
    resp_ready = 1;
    k = 0;
    while (!req_ready && k < 10) begin cyc(); k++; end
    chk("bp_ready_back", {31'b0, req_ready}, 32'd1);
    drain();
    // address errors
    fetch_one(32'h80000002, r);
    chk("err_misal", {31'b0, r.err}, 32'd1);
    chk("err_misal_inst", r.inst, 32'h0);
    chk("err_misal_addr", r.a, 32'h80000002);
    drain();
    fetch_one(32'h80001000, r);
    chk("err_high", {31'b0, r.err}, 32'd1);
    drain();
    fetch_one(32'h7FFFFFFC, r);
    chk("err_low", {31'b0, r.err}, 32'd1);
    chk("err_low_inst", r.inst, 32'h0);
    drain();
    // write hazard: load lands on the same edge as the store read
    req_valid = 1;
    req_addr = 32'h80000014;
    cyc();
    req_valid = 0;
    cyc();
    ld_wen = 1;
    ld_addr = 10'd5;
    ld_data = 32'hDEADBEEF;
    cyc();
    ld_wen = 0;
    chk("haz_old_valid", {31'b0, resp_valid}, 32'd1);
    chk("haz_old_inst", resp_inst, 32'h0BADF00D);
    drain();
    fetch_one(32'h80000014, r);
    chk("haz_new_inst", r.inst, 32'hDEADBEEF);
    drain();
    // reset mid-stream with three queued responses
    resp_ready = 0;
    req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h80000000 + 32'(4 * i);
      cyc();
    end
    req_valid = 0;
    cyc();
    cyc();
    chk("mid_queued", {31'b0, resp_valid}, 32'd1);
    rst = 0;
    pq.delete();
    fq.delete();
    live = 0;
    #1;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    cyc();
    rst = 1;
    resp_ready = 1;
    repeat (6) cyc();
    chk("mid_no_stale", {31'b0, resp_valid}, 32'd0);
`ifdef IMEM_FLUSH_EN
    // flush: two in flight, one buffered
    resp_ready = 0;
    req_valid = 1;
    req_addr = 32'h80000000;
    cyc();
    req_valid = 0;
    cyc();
    req_valid = 1;
    req_addr = 32'h80000004;
    cyc();
    req_addr = 32'h80000008;
    cyc();
    flush = 1;
    req_addr = 32'h8000000C;
    #1;
    chk("fl_ready_low", {31'b0, req_ready}, 32'd0);
    cyc();
    flush = 0;
    req_valid = 0;
    chk("fl_valid_low", {31'b0, resp_valid}, 32'd0);
    fetch_one(32'h80000010, r);
    chk("fl_first_after", r.a, 32'h80000010);
    drain();
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_addr = rand_addr();
      resp_ready = $urandom_range(0, 3) != 0;
      ld_wen = $urandom_range(0, 7) == 0;
      ld_addr = 10'($urandom_range(0, 1023));
      ld_data = $urandom;
`ifdef IMEM_FLUSH_EN
      flush = $urandom_range(0, 31) == 0;
`endif
      cyc();
    end
    ld_wen = 0;
    flush = 0;
    drain();
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
